// File: rtl/life_monitor.sv
// Classifies successive Game-of-Life generations (extinct / still / period-2 / running)
// and reports transitions through a one-deep event buffer. Optional OSC2 support: LIFE_MONITOR_OSC2_EN.
module life_monitor #(
    parameter int N     = 4,
    parameter int GEN_W = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [N*N-1:0]           cells,
    input  logic                     sample_en,
    output logic [$clog2(N*N+1)-1:0] population,
    output logic [GEN_W-1:0]         gen_count,
    output logic [2:0]               state,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [2:0]               evt_code,
    output logic [GEN_W-1:0]         evt_gen,
    output logic                     evt_overflow
);

    localparam int CELLS = N * N;
    localparam int POP_W = $clog2(CELLS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARM    = 3'd1,
        RUN     = 3'd2,
        STILL   = 3'd3,
        OSC2    = 3'd4,
        EXTINCT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        EVT_NONE    = 3'd0,
        EVT_STILL   = 3'd1,
        EVT_OSC2    = 3'd2,
        EVT_EXTINCT = 3'd3,
        EVT_RESUME  = 3'd4
    } evt_e;

    logic [CELLS-1:0] p1_q, p1_d;
    logic             p1_vld_q, p1_vld_d;
`ifdef LIFE_MONITOR_OSC2_EN
    logic [CELLS-1:0] p2_q, p2_d;
    logic             p2_vld_q, p2_vld_d;
`endif
    logic [POP_W-1:0] pop_q, pop_d, pop_s;
    logic [GEN_W-1:0] gen_q, gen_d;
    state_e           state_q, state_d, class_s;
    logic             evt_valid_q, evt_valid_d;
    evt_e             evt_code_q, evt_code_d, raise_code;
    logic [GEN_W-1:0] evt_gen_q, evt_gen_d;
    logic             evt_ovf_q, evt_ovf_d;

    function automatic logic is_settled(input state_e s);
        return (s == STILL) || (s == OSC2) || (s == EXTINCT);
    endfunction

    always_comb begin : popcount
        pop_s = '0;
        for (int i = 0; i < CELLS; i++) begin
            pop_s = pop_s + POP_W'(cells[i]);
        end
    end

    // Later assignments take priority: extinct beats still, still beats period-2.
    always_comb begin : classify
        class_s = p1_vld_q ? RUN : WARM;
`ifdef LIFE_MONITOR_OSC2_EN
        if (p2_vld_q && (cells == p2_q) && (cells != p1_q)) class_s = OSC2;
`endif
        if (p1_vld_q && (cells == p1_q)) class_s = STILL;
        if (cells == '0) class_s = EXTINCT;
    end

    always_comb begin : event_detect
        raise_code = EVT_NONE;
        if (class_s != state_q) begin
            case (class_s)
                STILL:   raise_code = EVT_STILL;
                OSC2:    raise_code = EVT_OSC2;
                EXTINCT: raise_code = EVT_EXTINCT;
                RUN:     if (is_settled(state_q)) raise_code = EVT_RESUME;
                default: raise_code = EVT_NONE;
            endcase
        end
    end

    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    always_comb begin : next_state
        p1_d        = p1_q;
        p1_vld_d    = p1_vld_q;
`ifdef LIFE_MONITOR_OSC2_EN
        p2_d        = p2_q;
        p2_vld_d    = p2_vld_q;
`endif
        pop_d       = pop_q;
        gen_d       = gen_q;
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_gen_d   = evt_gen_q;
        evt_ovf_d   = evt_ovf_q;

        if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

        if (sample_en) begin
            p1_d     = cells;
            p1_vld_d = 1'b1;
`ifdef LIFE_MONITOR_OSC2_EN
            p2_d     = p1_q;
            p2_vld_d = p1_vld_q;
`endif
            pop_d    = pop_s;
            gen_d    = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
            state_d  = class_s;
            if (raise_code != EVT_NONE) begin
                // A pending event that is not leaving this cycle is lost: flag it.
                if (evt_valid_q && !evt_ready) evt_ovf_d = 1'b1;
                evt_valid_d = 1'b1;
                evt_code_d  = raise_code;
                evt_gen_d   = gen_d;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; history is cleared too,
    // not just its valid bits, so no stale grid survives a reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            p1_q        <= '0;
            p1_vld_q    <= 1'b0;
`ifdef LIFE_MONITOR_OSC2_EN
            p2_q        <= '0;
            p2_vld_q    <= 1'b0;
`endif
            pop_q       <= '0;
            gen_q       <= '0;
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_NONE;
            evt_gen_q   <= '0;
            evt_ovf_q   <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            p1_vld_q    <= p1_vld_d;
`ifdef LIFE_MONITOR_OSC2_EN
            p2_q        <= p2_d;
            p2_vld_q    <= p2_vld_d;
`endif
            pop_q       <= pop_d;
            gen_q       <= gen_d;
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_gen_q   <= evt_gen_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end

    assign population   = pop_q;
    assign gen_count    = gen_q;
    assign state        = state_q;
    assign evt_valid    = evt_valid_q;
    assign evt_code     = evt_code_q;
    assign evt_gen      = evt_gen_q;
    assign evt_overflow = evt_ovf_q;

endmodule

// File: tb/tb_life_monitor.sv
// Self-checking bench for life_monitor: directed vector table, saturation/reset sequence,
// then randomized stimulus against a sample-history reference model.
module tb_life_monitor;

`ifdef LIFE_MONITOR_OSC2_EN
    localparam bit OSC_EN = 1'b1;
`else
    localparam bit OSC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        sample_en;
    logic [15:0] cells;
    logic        evt_ready;

    logic [4:0]  pop16, pop4;
    logic [15:0] gen16, egen16;
    logic [3:0]  gen4, egen4;
    logic [2:0]  st16, st4, code16, code4;
    logic        ev16, ev4, ovf16, ovf4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    life_monitor #(.N(4), .GEN_W(16)) u_dut (
        .clk(clk), .nrst(nrst), .cells(cells), .sample_en(sample_en),
        .population(pop16), .gen_count(gen16), .state(st16),
        .evt_valid(ev16), .evt_ready(evt_ready), .evt_code(code16),
        .evt_gen(egen16), .evt_overflow(ovf16)
    );

    life_monitor #(.N(4), .GEN_W(4)) u_sat (
        .clk(clk), .nrst(nrst), .cells(cells), .sample_en(sample_en),
        .population(pop4), .gen_count(gen4), .state(st4),
        .evt_valid(ev4), .evt_ready(evt_ready), .evt_code(code4),
        .evt_gen(egen4), .evt_overflow(ovf4)
    );

    typedef struct {
        logic        nrst;
        logic        se;
        logic [15:0] cells;
        logic        rdy;
        logic [2:0]  st;
        logic [4:0]  pop;
        logic [15:0] gen;
        logic        ev;
        logic [2:0]  code;
        logic [15:0] egen;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic se, input logic [15:0] c, input logic rdy,
                                input logic [2:0] st, input logic [4:0] pop, input logic [15:0] gen,
                                input logic ev, input logic [2:0] code, input logic [15:0] egen,
                                input logic ovf);
        vec_t v;
        v.nrst = r; v.se = se; v.cells = c; v.rdy = rdy;
        v.st = st; v.pop = pop; v.gen = gen; v.ev = ev; v.code = code; v.egen = egen; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the sample history is a queue; states/codes use the numeric encoding of the interface.
    logic [15:0] m_hist[$];
    int unsigned m_cnt, m_ev_cnt;
    int          m_state, m_pop, m_code;
    bit          m_ev, m_ovf;

    task automatic model_step(input bit rst_n, input bit se, input logic [15:0] s, input bit rdy);
        int  nxt;
        int  code;
        bit  was_pending;
        if (!rst_n) begin
            m_hist.delete();
            m_cnt = 0; m_ev_cnt = 0; m_state = 0; m_pop = 0; m_code = 0; m_ev = 0; m_ovf = 0;
            return;
        end
        was_pending = m_ev;
        if (m_ev && rdy) m_ev = 0;
        if (!se) return;
        m_cnt++;
        if (s == 16'h0)                                              nxt = 5;
        else if (m_hist.size() >= 1 && s == m_hist[m_hist.size()-1]) nxt = 3;
        else if (OSC_EN && m_hist.size() >= 2 && s == m_hist[m_hist.size()-2]) nxt = 4;
        else if (m_hist.size() >= 1)                                 nxt = 2;
        else                                                         nxt = 1;
        code = 0;
        if (nxt != m_state) begin
            if (nxt == 3)      code = 1;
            else if (nxt == 4) code = 2;
            else if (nxt == 5) code = 3;
            else if (nxt == 2 && m_state >= 3) code = 4;
        end
        if (code != 0) begin
            if (was_pending && !rdy) m_ovf = 1;
            m_ev = 1; m_code = code; m_ev_cnt = m_cnt;
        end
        m_hist.push_back(s);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        m_pop   = $countones(s);
        m_state = nxt;
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        nrst = 1'b0; sample_en = 1'b0; cells = '0; evt_ready = 1'b0;

        //        nrst se  cells      rdy   st    pop gen  ev code egen ovf
        vecs.push_back(mk(0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(0, 1, 16'hFFFF, 1, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0000, 0, 3'd5, 0, 1, 1, 3'd3, 1, 0));
        vecs.push_back(mk(1, 0, 16'hFFFF, 0, 3'd5, 0, 1, 1, 3'd3, 1, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 3'd5, 0, 1, 0, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0660, 1, 3'd1, 4, 1, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0660, 1, 3'd3, 4, 2, 1, 3'd1, 2, 0));
        vecs.push_back(mk(1, 1, 16'h0660, 1, 3'd3, 4, 3, 0, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h00F0, 1, 3'd1, 4, 1, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0F00, 1, 3'd2, 4, 2, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h00F0, 1, OSC_EN ? 3'd4 : 3'd2, 4, 3, OSC_EN, 3'd2, 3, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0660, 0, 3'd1, 4, 1, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0660, 0, 3'd3, 4, 2, 1, 3'd1, 2, 0));
        vecs.push_back(mk(1, 1, 16'h0001, 0, 3'd2, 1, 3, 1, 3'd4, 3, 1));
        vecs.push_back(mk(1, 1, 16'h0000, 0, 3'd5, 0, 4, 1, 3'd3, 4, 1));
        vecs.push_back(mk(1, 0, 16'h0660, 0, 3'd5, 0, 4, 1, 3'd3, 4, 1));
        vecs.push_back(mk(0, 1, 16'h0660, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0660, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0000, 0, 3'd5, 0, 1, 1, 3'd3, 1, 0));
        vecs.push_back(mk(1, 1, 16'h0001, 1, 3'd2, 1, 2, 1, 3'd4, 2, 0));
        vecs.push_back(mk(1, 0, 16'h0001, 1, 3'd2, 1, 2, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0002, 1, 3'd2, 1, 3, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 1, 3'd2, 16, 4, 0, 3'd0, 0, 0));

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            nrst = vecs[i].nrst; sample_en = vecs[i].se; cells = vecs[i].cells; evt_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d state", i),     32'(st16),  32'(vecs[i].st));
            check($sformatf("vec%0d population", i), 32'(pop16), 32'(vecs[i].pop));
            check($sformatf("vec%0d gen_count", i), 32'(gen16), 32'(vecs[i].gen));
            check($sformatf("vec%0d evt_valid", i), 32'(ev16),  32'(vecs[i].ev));
            check($sformatf("vec%0d evt_overflow", i), 32'(ovf16), 32'(vecs[i].ovf));
            if (vecs[i].ev || !vecs[i].nrst) begin
                check($sformatf("vec%0d evt_code", i), 32'(code16), 32'(vecs[i].code));
                check($sformatf("vec%0d evt_gen", i),  32'(egen16), 32'(vecs[i].egen));
            end
        end

        // Saturation on the 4-bit instance, then a reset that coincides with a sample.
        nrst = 1'b0; sample_en = 1'b0; tick();
        nrst = 1'b1; sample_en = 1'b1; cells = 16'h0001; evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat gen_count", 32'(gen4), 32'd15);
        check("wide gen_count", 32'(gen16), 32'd20);
        check("sat state", 32'(st4), 32'd3);
        check("sat evt_code before reset", 32'(code4), 32'd1);
        nrst = 1'b0; sample_en = 1'b1; tick();
        check("rst population", 32'(pop4), 32'd0);
        check("rst gen_count", 32'(gen4), 32'd0);
        check("rst state", 32'(st4), 32'd0);
        check("rst evt_valid", 32'(ev4), 32'd0);
        check("rst evt_code", 32'(code4), 32'd0);
        check("rst evt_gen", 32'(egen4), 32'd0);
        check("rst evt_overflow", 32'(ovf4), 32'd0);

        // Randomized run against the reference model.
        model_step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int unsigned pick;
            nrst      = ($urandom_range(0, 59) != 0);
            sample_en = ($urandom_range(0, 3) != 0);
            evt_ready = ($urandom_range(0, 2) == 0);
            pick = $urandom_range(0, 7);
            case (pick)
                0:       cells = 16'h0000;
                1, 2:    cells = 16'h00F0;
                3, 4:    cells = 16'h0F00;
                5:       cells = cells;
                default: cells = 16'($urandom);
            endcase
            model_step(nrst, sample_en, cells, evt_ready);
            tick();
            check("rnd state", 32'(st16), 32'(m_state));
            check("rnd population", 32'(pop16), 32'(m_pop));
            check("rnd gen_count", 32'(gen16), sat(m_cnt, 65535));
            check("rnd evt_valid", 32'(ev16), 32'(m_ev));
            check("rnd evt_overflow", 32'(ovf16), 32'(m_ovf));
            check("rnd sat gen_count", 32'(gen4), sat(m_cnt, 15));
            check("rnd sat state", 32'(st4), 32'(m_state));
            check("rnd sat evt_valid", 32'(ev4), 32'(m_ev));
            if (m_ev) begin
                check("rnd evt_code", 32'(code16), 32'(m_code));
                check("rnd evt_gen", 32'(egen16), sat(m_ev_cnt, 65535));
                check("rnd sat evt_gen", 32'(egen4), sat(m_ev_cnt, 15));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/life_monitor.md
LIFE_MONITOR -- requirements
Module: life_monitor

Interface
REQ-001 SHALL have parameter N, default 4, grid side; it monitors an N*N cell vector.
REQ-002 SHALL have parameter GEN_W, default 16, generation counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port nrst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cells  input  N*N  current generation from the life grid; bit i*N+j is row i, column j.
REQ-006 SHALL have port sample_en  input  1  high means cells holds a new generation to classify.
REQ-007 SHALL have port population  output  clog2(N*N+1)  live-cell count of the last sample.
REQ-008 SHALL have port gen_count  output  GEN_W  number of samples taken since reset.
REQ-009 SHALL have port state  output  3  0 IDLE, 1 WARM, 2 RUN, 3 STILL, 4 OSC2, 5 EXTINCT.
REQ-010 SHALL have port evt_valid  output  1  an event is pending.
REQ-011 SHALL have port evt_ready  input  1  the consumer accepts the event when evt_valid and evt_ready are both high.
REQ-012 SHALL have port evt_code  output  3  event code: 1 STILL, 2 OSC2, 3 EXTINCT, 4 RESUME.
REQ-013 SHALL have port evt_gen  output  GEN_W  gen_count value of the sample that raised the event.
REQ-014 SHALL have port evt_overflow  output  1  sticky flag; an unaccepted event was overwritten.

Function
REQ-015 SHALL hold history registers p1 (previous sample) and p2 (sample before p1), each with a valid bit; on each sample_en, s=cells, p2<=p1, p1<=s.
REQ-016 SHALL update population, gen_count, state and the event outputs on the same edge that captures sample_en, so results are visible one cycle after the sample.
REQ-017 SHALL increment gen_count by 1 per sample and saturate at 2^GEN_W-1.
REQ-018 SHALL compute population as the popcount of s with no truncation.
REQ-019 SHALL classify each sample in priority order: s==0 -> EXTINCT; p1 valid and s==p1 -> STILL; p2 valid and s==p2 and s!=p1 -> OSC2; otherwise RUN if p1 valid, WARM if p1 is not valid.
REQ-020 SHALL stay in IDLE until the first sample, and SHALL NOT change state in any cycle without sample_en.
REQ-021 SHALL raise an event with the matching code when state enters STILL, OSC2 or EXTINCT from any other state.
REQ-022 SHALL raise a RUN event, code 4 (RESUME), when state moves from STILL, OSC2 or EXTINCT to RUN.
REQ-023 SHALL raise no event when the new state equals the old state, nor on the transitions IDLE->WARM or WARM->RUN.
REQ-024 SHALL keep one event buffer; evt_valid, evt_code and evt_gen stay stable until accepted.
REQ-025 SHALL clear evt_valid on acceptance when no new event is raised in that same cycle.
REQ-026 SHALL load a new event, keep evt_valid high and leave evt_overflow unchanged when acceptance and a new event coincide.
REQ-027 SHALL overwrite the buffer with a new event and set evt_overflow when the new event arrives while an event is pending and not being accepted.

Reset
REQ-028 SHALL, while nrst is low at a rising edge, clear p1, p2, both valid bits, population, gen_count, evt_valid, evt_code, evt_gen and evt_overflow to 0, and set state to IDLE.
REQ-029 SHALL let reset override a simultaneous sample_en, and SHALL discard any pending event on reset mid-operation.

Configuration
REQ-030 SHALL, with macro LIFE_MONITOR_OSC2_EN defined, include the p2 history and the OSC2 classification and event.
REQ-031 SHALL, without LIFE_MONITOR_OSC2_EN, omit p2 and its valid bit, never enter OSC2 and never emit code 2; a period-2 pattern then classifies as RUN.

Verification
REQ-032 SHALL cover: N=4, one sample of 16'h0000 -> next cycle state=5, evt_valid=1, evt_code=3, evt_gen=1, population=0.
REQ-033 SHALL cover: 16'h0660 sampled three times, evt_ready=1 -> WARM, then STILL with evt_code=1 and evt_gen=2, population=4, no event on sample 3.
REQ-034 SHALL cover: 16'h00F0, 16'h0F00, 16'h00F0 with LIFE_MONITOR_OSC2_EN defined -> OSC2 event evt_gen=3; without the macro -> state RUN and no event.
REQ-035 SHALL cover: evt_ready=0, samples 16'h0660, 16'h0660, 16'h0001, 16'h0000 -> evt_code=3, evt_gen=4, evt_overflow=1.
REQ-036 SHALL cover: GEN_W=4 with 20 samples of 16'h0001 -> gen_count=15; then nrst=0 for one cycle together with sample_en=1 -> every output 0, state IDLE.
